// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl
// Hazard and forwarding control for a branch resolved in the ID stage.
// The branch compares its source registers in ID, so an in-flight producer
// must either forward its result into ID or stall the branch until the
// result becomes available.
//
// Ports
//   clock_i, reset_i        : clock, asynchronous active-high reset
//   ID_branch_i             : a branch instruction is in ID
//   ID_rs_i, ID_rt_i        : source registers of the branch
//   ID_EX_*                 : producer in EX  (write_reg, reg_write, mem_read)
//   EX_MEM_*                : producer in MEM (write_reg, reg_write, mem_read)
//   MEM_WB_*                : producer in WB  (write_reg, reg_write)
//   kill_i                  : ID is being flushed, so any stall is dropped
//   forward_A_o/forward_B_o : 00 register file, 01 EX/MEM, 10 MEM/WB (combinational)
//   stall_o                 : holds PC and IF/ID and bubbles ID/EX (combinational)
//   stall_count_o           : saturating count of stalled cycles
//
// Optional feature: define BRANCH_HAZARD_STATS_EN to build the stall
// statistics counter and the stall_count_o port.
module branch_hazard_ctrl #(
  parameter int unsigned NB_REG = 5,
  parameter int unsigned NB_CNT = 32
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              ID_branch_i,
  input  logic [NB_REG-1:0] ID_rs_i,
  input  logic [NB_REG-1:0] ID_rt_i,
  input  logic [NB_REG-1:0] ID_EX_write_reg_i,
  input  logic              ID_EX_reg_write_i,
  input  logic              ID_EX_mem_read_i,
  input  logic [NB_REG-1:0] EX_MEM_write_reg_i,
  input  logic              EX_MEM_reg_write_i,
  input  logic              EX_MEM_mem_read_i,
  input  logic [NB_REG-1:0] MEM_WB_write_reg_i,
  input  logic              MEM_WB_reg_write_i,
  input  logic              kill_i,
  output logic [1:0]        forward_A_o,
  output logic [1:0]        forward_B_o,
`ifdef BRANCH_HAZARD_STATS_EN
  output logic [NB_CNT-1:0] stall_count_o,
`endif
  output logic              stall_o
);

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EXM  = 2'b01;
  localparam logic [1:0] FWD_MWB  = 2'b10;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  // Producer writes the source register; register 0 never matches.
  function automatic logic reg_match(input logic              reg_write,
                                     input logic [NB_REG-1:0] write_reg,
                                     input logic [NB_REG-1:0] src);
    return reg_write && (write_reg == src) && (src != '0);
  endfunction

  // Forward source selection: EX/MEM (non-load) beats MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic exm_match,
                                         input logic mwb_match);
    if (exm_match && !EX_MEM_mem_read_i) return FWD_EXM;
    if (mwb_match)                       return FWD_MWB;
    return FWD_RF;
  endfunction

  // Cycles a single source must wait before its value can reach ID.
  function automatic logic [1:0] src_need(input logic idex_match,
                                          input logic exm_match);
    if (idex_match && ID_EX_mem_read_i)                 return 2'd2;
    if (idex_match || (exm_match && EX_MEM_mem_read_i)) return 2'd1;
    return 2'd0;
  endfunction

  logic       idex_rs_c, idex_rt_c;
  logic       exm_rs_c,  exm_rt_c;
  logic       mwb_rs_c,  mwb_rt_c;
  logic [1:0] need_rs_c, need_rt_c, need_c;

  // Source match terms
  always_comb begin
    idex_rs_c = reg_match(ID_EX_reg_write_i,  ID_EX_write_reg_i,  ID_rs_i);
    idex_rt_c = reg_match(ID_EX_reg_write_i,  ID_EX_write_reg_i,  ID_rt_i);
    exm_rs_c  = reg_match(EX_MEM_reg_write_i, EX_MEM_write_reg_i, ID_rs_i);
    exm_rt_c  = reg_match(EX_MEM_reg_write_i, EX_MEM_write_reg_i, ID_rt_i);
    mwb_rs_c  = reg_match(MEM_WB_reg_write_i, MEM_WB_write_reg_i, ID_rs_i);
    mwb_rt_c  = reg_match(MEM_WB_reg_write_i, MEM_WB_write_reg_i, ID_rt_i);
  end

  // Forward selects are not masked while stalling; consumers ignore them then.
  always_comb begin
    forward_A_o = fwd_sel(exm_rs_c, mwb_rs_c);
    forward_B_o = fwd_sel(exm_rt_c, mwb_rt_c);
  end

  // Stall need is the worse of the two sources, only for a branch in ID.
  always_comb begin
    need_rs_c = src_need(idex_rs_c, exm_rs_c);
    need_rt_c = src_need(idex_rt_c, exm_rt_c);
    need_c    = 2'd0;
    if (ID_branch_i) begin
      need_c = (need_rs_c > need_rt_c) ? need_rs_c : need_rt_c;
    end
  end

  state_e     state_q, state_d;
  logic [1:0] cnt_q,   cnt_d;
  logic       stall_c;

  // State register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and stall. RUN covers the first stall cycle itself, so a
  // two-cycle need only spends one cycle in STALL.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    if (kill_i) begin
      state_d = RUN;
      cnt_d   = 2'd0;
    end else begin
      unique case (state_q)
        RUN: begin
          stall_c = (need_c != 2'd0);
          if (need_c == 2'd2) begin
            state_d = STALL;
            cnt_d   = 2'd1;
          end else begin
            cnt_d   = 2'd0;
          end
        end
        STALL: begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - 2'(1);
          if (cnt_q == 2'd1) state_d = RUN;
        end
        default: begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // Reset drops the stall immediately, even while a hazard is present.
  assign stall_o = stall_c & ~reset_i;

`ifdef BRANCH_HAZARD_STATS_EN
  logic [NB_CNT-1:0] stall_count_q, stall_count_d;

  // Saturating count of cycles with stall_o asserted
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_o && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + NB_CNT'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) stall_count_q <= '0;
    else         stall_count_q <= stall_count_d;
  end

  assign stall_count_o = stall_count_q;
`else
  // Keeps the counter width parameter referenced when statistics are absent.
  logic [NB_CNT-1:0] unused_stats_c;
  assign unused_stats_c = '0;
`endif

endmodule

// File: doc/branch_hazard_ctrl.md
BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
- REQ-001 SHALL have parameter NB_REG, default 5, register-index width.
- REQ-002 SHALL have parameter NB_CNT, default 32, stall-statistics counter width.
- REQ-003 SHALL have port clock_i, input, 1, the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port reset_i, input, 1, asynchronous active-high reset.
- REQ-005 SHALL have ports ID_branch_i (input, 1), ID_rs_i (input, NB_REG) and ID_rt_i (input, NB_REG): branch present in ID and its source registers.
- REQ-006 SHALL have ports ID_EX_write_reg_i (input, NB_REG), ID_EX_reg_write_i (input, 1) and ID_EX_mem_read_i (input, 1): producer in EX.
- REQ-007 SHALL have ports EX_MEM_write_reg_i (input, NB_REG), EX_MEM_reg_write_i (input, 1) and EX_MEM_mem_read_i (input, 1): producer in MEM.
- REQ-008 SHALL have ports MEM_WB_write_reg_i (input, NB_REG) and MEM_WB_reg_write_i (input, 1): producer in WB.
- REQ-009 SHALL have port kill_i, input, 1, aborts any stall in progress (ID flushed).
- REQ-010 SHALL have ports forward_A_o and forward_B_o, output, 2 each: 00 register file, 01 EX/MEM, 10 MEM/WB; 11 never driven.
- REQ-011 SHALL have port stall_o, output, 1: holds PC and IF/ID and bubbles ID/EX.
- REQ-012 SHALL have port stall_count_o, output, NB_CNT, present only per REQ-027.

Function
- REQ-013 Match on a source register SHALL require producer reg_write=1, write_reg equal to the source, and source != 0; register 0 never forwards or stalls.
- REQ-014 Forward select SHALL be combinational: 01 if EX/MEM matches and EX_MEM_mem_read_i=0; else 10 if MEM/WB matches; else 00; EX/MEM has priority over MEM/WB.
- REQ-015 Stall need N (0..2) SHALL be computed combinationally when ID_branch_i=1, as the maximum over rs and rt: ID/EX load match -> 2; ID/EX non-load match -> 1; EX/MEM load match -> 1; otherwise 0. N=0 when ID_branch_i=0.
- REQ-016 FSM SHALL have states RUN and STALL and a 2-bit remaining counter cnt.
- REQ-017 In RUN: stall_o = (N>0); if N=2, next state STALL with cnt<=1; otherwise remain in RUN with cnt<=0.
- REQ-018 In STALL: stall_o=1 regardless of N; cnt<=cnt-1; return to RUN when cnt=1.
- REQ-019 On re-entry to RUN, N SHALL be re-evaluated; a residual dependency stalls again under REQ-017.
- REQ-020 kill_i=1 SHALL force stall_o=0 combinationally and next state RUN with cnt<=0; kill wins over any simultaneous new hazard.
- REQ-021 Forward outputs SHALL be valid for consumption only when stall_o=0; they are not masked during stall.
- REQ-022 Latency: hazard detection to stall_o is 0 cycles; total stall cycles are exactly N (absent kill).

Reset
- REQ-023 reset_i=1 SHALL asynchronously force state RUN, cnt 0, and stall_count_o 0.
- REQ-024 During reset, stall_o SHALL be 0; forward outputs SHALL follow REQ-014 (combinational).
- REQ-025 Reset asserted in STALL SHALL abort the stall immediately; after deassertion the FSM behaves as in RUN.

Configuration
- REQ-026 Macro BRANCH_HAZARD_STATS_EN SHALL gate the statistics feature.
- REQ-027 With BRANCH_HAZARD_STATS_EN defined: stall_count_o exists and increments by 1 on every clock edge where stall_o=1, saturating at all-ones. Without it: the port and the counter logic are absent.

Verification
- REQ-028 ID/EX load writes r5; branch in ID reads rs=r5 -> stall_o=1 for exactly 2 cycles; then forward_A_o=10 once the producer reaches WB.
- REQ-029 ID/EX ALU op writes r7; branch reads rt=r7 -> stall 1 cycle; next cycle forward_B_o=01.
- REQ-030 EX/MEM writes r3 and MEM/WB writes r3; branch reads rs=r3 -> forward_A_o=01, stall_o=0.
- REQ-031 Producer writes r0 with reg_write=1; branch reads r0 -> forward 00, no stall.
- REQ-032 Load-use 2-cycle stall with kill_i=1 in the 2nd cycle -> stall_o=0 that cycle, state RUN next; reset mid-STALL -> stall_o=0 immediately.
- REQ-033 With BRANCH_HAZARD_STATS_EN and NB_CNT=2: 5 stall cycles -> stall_count_o saturates at 3.
